// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared processing-unit constants and types
package riscv_pkg;

    localparam logic [4:0] LINK_1 = 5'd1;

    localparam int RAS_DEPTH = 8;

    // Encoded directly as {push, pop} so decode is a plain cast.
    typedef enum logic [1:0] {
        RAS_NONE     = 2'b00,
        RAS_POP      = 2'b01,
        RAS_PUSH     = 2'b10,
        RAS_POP_PUSH = 2'b11
    } ras_op_t;

endpackage

// File: rtl/riscv_pu_ras.sv
// rtl/riscv_pu_ras.sv - circular return-address stack feeding the LINK_1 write path
module riscv_pu_ras
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = RAS_DEPTH
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  enable,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_push_addr,
    output logic                  o_ras_read,
    output logic [DATA_WIDTH-1:0] o_ras_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [PW-1:0]         ptr_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] entries [DEPTH] = '{default: '0};

    logic          op_en;
    ras_op_t       op;
    logic          has_entry;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;
    logic          wr_en;
    logic [PW-1:0] wr_ptr;

    assign op_en     = enable && !i_stall;
    assign op        = ras_op_t'({i_push, i_pop});
    assign has_entry = (count_q != '0);
    assign ptr_inc   = ptr_q + 1'b1;
    assign ptr_dec   = ptr_q - 1'b1;

    // A push-only advances first; a link-swap overwrites the current top in place.
    assign wr_en  = op_en && !i_flush && i_push;
    assign wr_ptr = (op == RAS_PUSH) ? ptr_inc : ptr_q;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == COUNT_FULL);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries[wr_ptr] <= i_push_addr;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr_q       <= '0;
            count_q     <= '0;
            o_ras_read  <= 1'b0;
            o_ras_data  <= '0;
            o_underflow <= 1'b0;
        end else if (op_en) begin
            o_ras_read  <= 1'b0;
            o_underflow <= 1'b0;
            if (i_flush) begin
                ptr_q   <= '0;
                count_q <= '0;
            end else begin
                case (op)
                    RAS_PUSH: begin
                        ptr_q <= ptr_inc;
                        if (count_q != COUNT_FULL) begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    RAS_POP: begin
                        if (has_entry) begin
                            o_ras_data <= entries[ptr_q];
                            o_ras_read <= 1'b1;
                            ptr_q      <= ptr_dec;
                            count_q    <= count_q - 1'b1;
                        end else begin
                            o_underflow <= 1'b1;
                        end
                    end
                    RAS_POP_PUSH: begin
                        o_ras_data  <= entries[ptr_q];
                        o_ras_read  <= has_entry;
                        o_underflow <= !has_entry;
                        if (!has_entry) begin
                            count_q <= CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end else begin
            o_ras_read  <= 1'b0;
            o_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_pu_ras.sv
// tb/tb_riscv_pu_ras.sv - self-checking bench for riscv_pu_ras against a queue-based stack model
module tb_riscv_pu_ras;

    localparam int DW    = 64;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          nreset;
    logic          enable;
    logic          i_stall;
    logic          i_flush;
    logic          i_push;
    logic          i_pop;
    logic [DW-1:0] i_push_addr;
    logic          o_ras_read;
    logic [DW-1:0] o_ras_data;
    logic          o_empty;
    logic          o_full;
    logic          o_underflow;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] stack_q[$];
    logic [DW-1:0] exp_data;
    logic          data_known;
    logic          exp_read;
    logic          exp_uf;

    riscv_pu_ras #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .enable      (enable),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .i_push      (i_push),
        .i_pop       (i_pop),
        .i_push_addr (i_push_addr),
        .o_ras_read  (o_ras_read),
        .o_ras_data  (o_ras_data),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stack_q.delete();
        exp_data   = '0;
        data_known = 1'b1;
        exp_read   = 1'b0;
        exp_uf     = 1'b0;
    endtask

    // Stack semantics: newest at the back, oldest falls off the front on overflow.
    task automatic model_step(input logic en, input logic st, input logic fl,
                              input logic pu, input logic po, input logic [DW-1:0] addr);
        exp_read = 1'b0;
        exp_uf   = 1'b0;
        if (en && !st) begin
            if (fl) begin
                stack_q.delete();
            end else if (pu && po) begin
                if (stack_q.size() > 0) begin
                    exp_read   = 1'b1;
                    exp_data   = stack_q[$];
                    data_known = 1'b1;
                    stack_q[stack_q.size()-1] = addr;
                end else begin
                    exp_uf     = 1'b1;
                    data_known = 1'b0;
                    stack_q.push_back(addr);
                end
            end else if (pu) begin
                stack_q.push_back(addr);
                if (stack_q.size() > DEPTH) void'(stack_q.pop_front());
            end else if (po) begin
                if (stack_q.size() > 0) begin
                    exp_read   = 1'b1;
                    exp_data   = stack_q.pop_back();
                    data_known = 1'b1;
                end else begin
                    exp_uf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".read"},  DW'(o_ras_read),  DW'(exp_read));
        check({tag, ".uf"},    DW'(o_underflow), DW'(exp_uf));
        check({tag, ".empty"}, DW'(o_empty),     DW'(stack_q.size() == 0));
        check({tag, ".full"},  DW'(o_full),      DW'(stack_q.size() == DEPTH));
        if (data_known) check({tag, ".data"}, o_ras_data, exp_data);
    endtask

    task automatic step(input string tag, input logic en, input logic st, input logic fl,
                        input logic pu, input logic po, input logic [DW-1:0] addr);
        enable = en; i_stall = st; i_flush = fl; i_push = pu; i_pop = po; i_push_addr = addr;
        @(posedge clk);
        #1;
        model_step(en, st, fl, pu, po, addr);
        check_all(tag);
        enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_push = 1'b0; i_pop = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] a);
        step("push", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        model_reset();
        #1;
        check_all("reset");
    endtask

    initial begin
        nreset = 1'b0; enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        i_push = 1'b0; i_pop = 1'b0; i_push_addr = '0;
        do_reset();
        check("reset.data0", o_ras_data, 64'h0);

        // LIFO order
        push(64'h1000); push(64'h2000); push(64'h3000);
        pop("lifo1"); check("lifo1.val", o_ras_data, 64'h3000);
        pop("lifo2"); check("lifo2.val", o_ras_data, 64'h2000);
        pop("lifo3"); check("lifo3.val", o_ras_data, 64'h1000);
        check("lifo.empty", DW'(o_empty), 64'd1);

        // Overflow wrap then drain to underflow
        for (int i = 1; i <= 9; i++) begin
            push(DW'(i) << 8);
            if (i == 8) check("ovf.full8", DW'(o_full), 64'd1);
        end
        for (int i = 9; i >= 2; i--) begin
            pop("drain");
            check("drain.val", o_ras_data, DW'(i) << 8);
        end
        pop("drain_uf");
        check("drain_uf.uf",   DW'(o_underflow), 64'd1);
        check("drain_uf.read", DW'(o_ras_read),  64'd0);
        check("drain_uf.hold", o_ras_data,       64'h200);

        // Link swap
        push(64'hA0);
        step("swap", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hB0);
        check("swap.val", o_ras_data, 64'hA0);
        pop("swap_pop"); check("swap_pop.val", o_ras_data, 64'hB0);
        check("swap_pop.empty", DW'(o_empty), 64'd1);

        // Stall, then global disable, freezing a pending pop
        for (int mode = 0; mode < 2; mode++) begin
            push(64'h10); push(64'h20);
            for (int k = 0; k < 3; k++)
                step("frozen", mode == 1 ? 1'b0 : 1'b1, mode == 0 ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b1, '0);
            pop("thaw"); check("thaw.val", o_ras_data, 64'h20);
            pop("thaw2");
        end

        // Flush wins over pop
        push(64'h10); push(64'h20);
        step("flush", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        check("flush.empty", DW'(o_empty), 64'd1);
        pop("flush_uf"); check("flush_uf.uf", DW'(o_underflow), 64'd1);

        // Async reset cancels an in-flight pop pulse
        push(64'h55);
        pop("pre_rst");
        check("pre_rst.read", DW'(o_ras_read), 64'd1);
        #2 nreset = 1'b0;
        #1;
        check("arst.read",  DW'(o_ras_read), 64'd0);
        check("arst.data",  o_ras_data,      64'h0);
        check("arst.empty", DW'(o_empty),    64'd1);
        @(negedge clk);
        nreset = 1'b1;
        model_reset();

        // Randomised traffic against the stack model
        for (int n = 0; n < 600; n++) begin
            step("rand",
                 $urandom_range(0, 15) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
